wb_regfile: RTL and testbench

- Write-back stage and architectural register file owner; the write side of the register data that the decode stage reads.
- Accepts retiring results from execute through a valid/ready handshake.
- Loads: issues a memory read request, waits for the response, then extracts and extends the addressed lane.
- Writes 64-bit GPRs (x0 hardwired zero) and exports the full array to decode, plus a retire/trace pulse for difftest.

---
 rtl/wb_regfile_pkg.sv | 27 ++
 rtl/wb_regfile_load_extend.sv | 47 ++++
 rtl/wb_regfile.sv | 192 +++++++++++++++++++
 tb/tb_wb_regfile.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared definitions for the write-back stage.
//   - wb_state_t      : write-back FSM states (WB_IDLE, WB_REQ, WB_WAIT)
//   - LD_B..LD_D      : load size codes carried on ex_ld_size
//   - REG_DATA_DEPTH  : number of GPRs
//   - REG_ADDR_WIDTH  : GPR address width
//   - ld_bytes()      : number of bytes touched by a load size code
package wb_regfile_pkg;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_REQ  = 2'd1,
        WB_WAIT = 2'd2
    } wb_state_t;

    localparam logic [1:0] LD_B = 2'd0;
    localparam logic [1:0] LD_H = 2'd1;
    localparam logic [1:0] LD_W = 2'd2;
    localparam logic [1:0] LD_D = 2'd3;

    localparam int REG_DATA_DEPTH = 32;
    localparam int REG_ADDR_WIDTH = 5;

    function automatic logic [3:0] ld_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/wb_regfile_load_extend.sv
// load_extend: combinational lane extraction and extension for loads.
// Ports:
//   data        in   XLEN  8-byte memory word, little-endian lanes
//   offset      in   3     byte offset of the access inside the word
//   size        in   2     LD_B / LD_H / LD_W / LD_D
//   ld_unsigned in   1     zero-extend instead of sign-extend (ignored for LD_D)
//   ext         out  XLEN  extracted and extended value
//   misalign    out  1     access would cross the 8-byte boundary
module load_extend
    import wb_regfile_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] data,
    input  logic [2:0]      offset,
    input  logic [1:0]      size,
    input  logic            ld_unsigned,
    output logic [XLEN-1:0] ext,
    output logic            misalign
);

    logic [XLEN-1:0] shifted;
    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;
    logic signed [31:0] lane_w;

    always_comb begin
        // Bring the addressed lane down to bit 0.
        shifted = data >> {offset, 3'b000};
        lane_b  = shifted[7:0];
        lane_h  = shifted[15:0];
        lane_w  = shifted[31:0];

        case (size)
            LD_B:    ext = ld_unsigned ? {{(XLEN-8){1'b0}}, lane_b}
                                       : {{(XLEN-8){lane_b[7]}}, lane_b};
            LD_H:    ext = ld_unsigned ? {{(XLEN-16){1'b0}}, lane_h}
                                       : {{(XLEN-16){lane_h[15]}}, lane_h};
            LD_W:    ext = ld_unsigned ? {{(XLEN-32){1'b0}}, lane_w}
                                       : {{(XLEN-32){lane_w[31]}}, lane_w};
            default: ext = shifted;
        endcase

        misalign = ({1'b0, offset} + ld_bytes(size)) > 4'd8;
    end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage and owner of the architectural GPR file.
// Retires ALU results directly; loads go through a one-outstanding memory
// read (REQ -> WAIT) and then get lane-extracted and extended.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   ex_valid/ex_ready                retire handshake from execute (ready in IDLE only)
//   ex_reg_wen, ex_reg_waddr         destination register control
//   ex_result                        ALU result, or effective address for loads
//   ex_is_load, ex_ld_size,
//   ex_ld_unsigned                   load descriptor
//   mem_req_valid/ready, mem_req_addr   8-byte aligned read request
//   mem_rsp_valid, mem_rsp_data      read response
//   reg_f                            full register array to decode (x0 reads 0)
//   wb_done, wb_wen, wb_waddr,
//   wb_wdata                         registered retire/trace pulse
//   ld_misalign                      registered pulse for boundary-crossing loads
// Optional build macro: WB_WRITE_THROUGH_EN makes reg_f present the pending
// write combinationally in the cycle before the register updates.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int NREG = REG_DATA_DEPTH,
    parameter int AW   = REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ex_valid,
    output logic                      ex_ready,
    input  logic                      ex_reg_wen,
    input  logic [AW-1:0]             ex_reg_waddr,
    input  logic [XLEN-1:0]           ex_result,
    input  logic                      ex_is_load,
    input  logic [1:0]                ex_ld_size,
    input  logic                      ex_ld_unsigned,
    output logic                      mem_req_valid,
    output logic [XLEN-1:0]           mem_req_addr,
    input  logic                      mem_req_ready,
    input  logic                      mem_rsp_valid,
    input  logic [XLEN-1:0]           mem_rsp_data,
    output logic [NREG-1:0][XLEN-1:0] reg_f,
    output logic                      wb_done,
    output logic                      wb_wen,
    output logic [AW-1:0]             wb_waddr,
    output logic [XLEN-1:0]           wb_wdata,
    output logic                      ld_misalign
);

    wb_state_t state_q, state_d;

    logic [NREG-1:0][XLEN-1:0] regs_q;

    logic [AW-1:0]   lat_rd;
    logic            lat_wen;
    logic [1:0]      lat_size;
    logic            lat_uns;
    logic [XLEN-1:0] lat_addr;

    logic [2:0]      ext_off;
    logic [1:0]      ext_size;
    logic [XLEN-1:0] ext_data;
    logic            ext_misalign;

    logic            alu_retire;
    logic            ld_accept;
    logic            rsp_take;

    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;

    // The extender serves two purposes: in IDLE it judges the incoming load's
    // alignment from ex_result, elsewhere it extracts from the latched access.
    assign ext_off  = (state_q == WB_IDLE) ? ex_result[2:0] : lat_addr[2:0];
    assign ext_size = (state_q == WB_IDLE) ? ex_ld_size     : lat_size;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .data        (mem_rsp_data),
        .offset      (ext_off),
        .size        (ext_size),
        .ld_unsigned (lat_uns),
        .ext         (ext_data),
        .misalign    (ext_misalign)
    );

    assign alu_retire   = (state_q == WB_IDLE) && ex_valid && !ex_is_load;
    assign ld_accept    = (state_q == WB_IDLE) && ex_valid && ex_is_load;
    assign rsp_take     = (state_q == WB_WAIT) && mem_rsp_valid;
    assign mem_req_addr = {lat_addr[XLEN-1:3], 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= WB_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        ex_ready      = 1'b0;
        mem_req_valid = 1'b0;
        case (state_q)
            WB_IDLE: begin
                ex_ready = 1'b1;
                if (ex_valid && ex_is_load && !ext_misalign) state_d = WB_REQ;
            end
            WB_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = WB_WAIT;
            end
            WB_WAIT: begin
                if (mem_rsp_valid) state_d = WB_IDLE;
            end
            default: state_d = WB_IDLE;
        endcase
    end

    // Single GPR write port shared by ALU retires and load responses; the two
    // sources are mutually exclusive by state.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = ex_reg_waddr;
        wr_data = ex_result;
        if (alu_retire) begin
            wr_en = ex_reg_wen && (ex_reg_waddr != '0);
        end else if (rsp_take) begin
            wr_en   = lat_wen && (lat_rd != '0);
            wr_addr = lat_rd;
            wr_data = ext_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_rd      <= '0;
            lat_wen     <= 1'b0;
            lat_size    <= '0;
            lat_uns     <= 1'b0;
            lat_addr    <= '0;
            wb_done     <= 1'b0;
            wb_wen      <= 1'b0;
            wb_waddr    <= '0;
            wb_wdata    <= '0;
            ld_misalign <= 1'b0;
        end else begin
            wb_done     <= 1'b0;
            wb_wen      <= 1'b0;
            ld_misalign <= 1'b0;
            if (alu_retire) begin
                wb_done  <= 1'b1;
                wb_wen   <= wr_en;
                wb_waddr <= ex_reg_waddr;
                wb_wdata <= ex_result;
            end else if (ld_accept) begin
                lat_rd   <= ex_reg_waddr;
                lat_wen  <= ex_reg_wen;
                lat_size <= ex_ld_size;
                lat_uns  <= ex_ld_unsigned;
                lat_addr <= ex_result;
                // A boundary-crossing load retires immediately without a write.
                if (ext_misalign) begin
                    wb_done     <= 1'b1;
                    ld_misalign <= 1'b1;
                    wb_waddr    <= ex_reg_waddr;
                    wb_wdata    <= '0;
                end
            end else if (rsp_take) begin
                wb_done  <= 1'b1;
                wb_wen   <= wr_en;
                wb_waddr <= lat_rd;
                wb_wdata <= ext_data;
            end
        end
    end

    always_comb begin
        reg_f    = regs_q;
`ifdef WB_WRITE_THROUGH_EN
        // Forward the write that lands on the next edge so decode sees it now.
        if (wr_en) reg_f[wr_addr] = wr_data;
`else
`endif
        reg_f[0] = '0;
    end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ex_valid;
    logic              ex_ready;
    logic              ex_reg_wen;
    logic [4:0]        ex_reg_waddr;
    logic [63:0]       ex_result;
    logic              ex_is_load;
    logic [1:0]        ex_ld_size;
    logic              ex_ld_unsigned;
    logic              mem_req_valid;
    logic [63:0]       mem_req_addr;
    logic              mem_req_ready;
    logic              mem_rsp_valid;
    logic [63:0]       mem_rsp_data;
    logic [31:0][63:0] reg_f;
    logic              wb_done;
    logic              wb_wen;
    logic [4:0]        wb_waddr;
    logic [63:0]       wb_wdata;
    logic              ld_misalign;

    wb_regfile dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_reg_wen     (ex_reg_wen),
        .ex_reg_waddr   (ex_reg_waddr),
        .ex_result      (ex_result),
        .ex_is_load     (ex_is_load),
        .ex_ld_size     (ex_ld_size),
        .ex_ld_unsigned (ex_ld_unsigned),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .reg_f          (reg_f),
        .wb_done        (wb_done),
        .wb_wen         (wb_wen),
        .wb_waddr       (wb_waddr),
        .wb_wdata       (wb_wdata),
        .ld_misalign    (ld_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_load;
        logic [4:0]  rd;
        bit          wen;
        logic [63:0] addr;   // ALU result or load address
        logic [1:0]  size;
        bit          uns;
        logic [63:0] rsp;
        logic [63:0] exp;    // expected written value
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] mdl [32];
    vec_t        tbl [13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chk_regs(input string name);
        int bad;
        bad = -1;
        for (int i = 0; i < 32; i++)
            if (bad < 0 && reg_f[i] !== mdl[i]) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s reg x%0d actual=%h expected=%h", name, bad, reg_f[bad], mdl[bad]);
        end
    endtask

    // Reference load semantics: gather bytes little-endian, then extend.
    function automatic logic [63:0] ld_model(input logic [63:0] data, input int off,
                                             input logic [1:0] size, input bit uns);
        int          n;
        logic [63:0] v;
        logic [63:0] ones;
        n    = 1 << size;
        v    = '0;
        ones = '1;
        for (int i = 0; i < n; i++)
            v = v | ({56'b0, data[8*(off+i) +: 8]} << (8*i));
        if (!uns && n < 8 && v[8*n-1]) v = v | (ones << (8*n));
        return v;
    endfunction

    task automatic idle_inputs();
        ex_valid       = 1'b0;
        ex_reg_wen     = 1'b0;
        ex_reg_waddr   = '0;
        ex_result      = '0;
        ex_is_load     = 1'b0;
        ex_ld_size     = '0;
        ex_ld_unsigned = 1'b0;
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 idle.
    task automatic run_op(input vec_t v, input int req_dly, input int rsp_dly, input string tag);
        bit   mis;
        bit   do_wr;
        logic [63:0] al;
        mis   = v.is_load && ((int'(v.addr[2:0]) + (1 << v.size)) > 8);
        do_wr = v.wen && (v.rd != 0) && !mis;
        al    = {v.addr[63:3], 3'b000};
        chk({tag, " ready"}, {63'b0, ex_ready}, 64'd1);
        ex_valid       = 1'b1;
        ex_reg_wen     = v.wen;
        ex_reg_waddr   = v.rd;
        ex_result      = v.addr;
        ex_is_load     = v.is_load;
        ex_ld_size     = v.size;
        ex_ld_unsigned = v.uns;
        @(posedge clk); #1;
        idle_inputs();
        if (!v.is_load || mis) begin
            if (do_wr) mdl[v.rd] = v.exp;
            chk({tag, " wb_done"}, {63'b0, wb_done}, 64'd1);
            chk({tag, " wb_wen"}, {63'b0, wb_wen}, {63'b0, do_wr});
            chk({tag, " misalign"}, {63'b0, ld_misalign}, {63'b0, mis});
            chk({tag, " req_valid"}, {63'b0, mem_req_valid}, 64'd0);
            if (do_wr) begin
                chk({tag, " wb_waddr"}, {59'b0, wb_waddr}, {59'b0, v.rd});
                chk({tag, " wb_wdata"}, wb_wdata, v.exp);
            end
        end else begin
            chk({tag, " req_valid"}, {63'b0, mem_req_valid}, 64'd1);
            chk({tag, " req_addr"}, mem_req_addr, al);
            chk({tag, " busy"}, {62'b0, ex_ready, wb_done}, 64'd0);
            for (int i = 0; i < req_dly; i++) begin
                @(posedge clk); #1;
                chk({tag, " req_hold"}, {63'b0, mem_req_valid}, 64'd1);
                chk({tag, " addr_hold"}, mem_req_addr, al);
            end
            mem_req_ready = 1'b1;
            @(posedge clk); #1;
            mem_req_ready = 1'b0;
            chk({tag, " wait"}, {62'b0, mem_req_valid, ex_ready}, 64'd0);
            for (int i = 0; i < rsp_dly; i++) begin @(posedge clk); #1; end
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = v.rsp;
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = {$urandom, $urandom};
            if (do_wr) mdl[v.rd] = ld_model(v.rsp, int'(v.addr[2:0]), v.size, v.uns);
            chk({tag, " wb_done"}, {63'b0, wb_done}, 64'd1);
            chk({tag, " wb_wen"}, {63'b0, wb_wen}, {63'b0, do_wr});
            chk({tag, " ready_back"}, {63'b0, ex_ready}, 64'd1);
            if (do_wr) begin
                chk({tag, " wb_waddr"}, {59'b0, wb_waddr}, {59'b0, v.rd});
                chk({tag, " wb_wdata"}, wb_wdata, v.exp);
            end
        end
        chk_regs({tag, " regs"});
        @(posedge clk); #1;
        chk({tag, " pulse_end"}, {61'b0, wb_done, wb_wen, ld_misalign}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        vec_t        v;
        d = 64'h0011_2233_8455_6677;
        tbl[0]  = '{0, 5'd5,  1, 64'h1234,   2'd0, 0, 64'd0, 64'h1234};
        tbl[1]  = '{0, 5'd0,  1, 64'hDEAD,   2'd0, 0, 64'd0, 64'd0};
        tbl[2]  = '{1, 5'd6,  1, 64'h1003,   2'd0, 0, d, 64'hFFFF_FFFF_FFFF_FF84};
        tbl[3]  = '{1, 5'd7,  1, 64'h1003,   2'd0, 1, d, 64'h84};
        tbl[4]  = '{1, 5'd8,  1, 64'h2004,   2'd2, 0, d, 64'h0000_0000_0011_2233};
        tbl[5]  = '{1, 5'd9,  1, 64'h2000,   2'd3, 1, d, 64'h0011_2233_8455_6677};
        tbl[6]  = '{1, 5'd5,  1, 64'h1007,   2'd1, 0, d, 64'd0};
        tbl[7]  = '{1, 5'd10, 1, 64'h1006,   2'd1, 1, d, 64'h0011};
        tbl[8]  = '{1, 5'd11, 1, 64'h1002,   2'd1, 0, d, 64'hFFFF_FFFF_FFFF_8455};
        tbl[9]  = '{1, 5'd12, 1, 64'h1000,   2'd2, 0, d, 64'hFFFF_FFFF_8455_6677};
        tbl[10] = '{1, 5'd13, 1, 64'h1000,   2'd2, 1, d, 64'h0000_0000_8455_6677};
        tbl[11] = '{1, 5'd0,  1, 64'h1001,   2'd0, 0, d, 64'd0};
        tbl[12] = '{1, 5'd14, 0, 64'h1008,   2'd3, 0, d, 64'd0};

        for (int i = 0; i < 32; i++) mdl[i] = '0;
        idle_inputs();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        rst_n         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset regs", {63'b0, reg_f == '0}, 64'd1);
        chk("reset ctrl", {60'b0, ex_ready, mem_req_valid, wb_done, ld_misalign}, 64'b1000);
        chk("reset wb", {wb_wdata[58:0], wb_waddr}, 64'd0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++)
            run_op(tbl[i], i % 3, i % 2, $sformatf("vec%0d", i));

        // Back-to-back ALU retires with ex_valid held high.
        ex_valid = 1'b1; ex_reg_wen = 1'b1; ex_reg_waddr = 5'd20; ex_result = 64'hAAAA_0001;
        @(posedge clk); #1;
        chk("b2b first data", wb_wdata, 64'hAAAA_0001);
        chk("b2b ready", {63'b0, ex_ready}, 64'd1);
        ex_reg_waddr = 5'd21; ex_result = 64'hBBBB_0002;
        @(posedge clk); #1;
        idle_inputs();
        mdl[20] = 64'hAAAA_0001;
        mdl[21] = 64'hBBBB_0002;
        chk("b2b second", {wb_waddr, wb_wdata[58:0]}, {5'd21, 59'(64'hBBBB_0002)});
        chk_regs("b2b regs");
        @(posedge clk); #1;

        // Randomized traffic against the reference model.
        for (int n = 0; n < 200; n++) begin
            v.is_load = ($urandom_range(0, 2) != 0);
            v.rd      = 5'($urandom_range(0, 31));
            v.wen     = ($urandom_range(0, 4) != 0);
            v.addr    = {$urandom, $urandom};
            v.size    = 2'($urandom_range(0, 3));
            v.uns     = 1'($urandom_range(0, 1));
            v.rsp     = {$urandom, $urandom};
            v.exp     = v.is_load ? ld_model(v.rsp, int'(v.addr[2:0]), v.size, v.uns) : v.addr;
            run_op(v, $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rnd%0d", n));
        end

        // Request stall, then reset while waiting for the response.
        ex_valid = 1'b1; ex_reg_wen = 1'b1; ex_reg_waddr = 5'd7; ex_result = 64'h3000;
        ex_is_load = 1'b1; ex_ld_size = 2'd3;
        @(posedge clk); #1;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            chk("stall valid", {62'b0, mem_req_valid, ex_ready}, 64'b10);
            chk("stall addr", mem_req_addr, 64'h3000);
            @(posedge clk); #1;
        end
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        chk("in wait", {62'b0, mem_req_valid, ex_ready}, 64'd0);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) mdl[i] = '0;
        chk_regs("async reset regs");
        chk("async reset ctrl", {62'b0, ex_ready, mem_req_valid}, 64'b10);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        chk("late rsp ignored", {62'b0, wb_done, wb_wen}, 64'd0);
        chk_regs("late rsp regs");
        chk("late rsp ready", {63'b0, ex_ready}, 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
